// File: rtl/fetch_ctrl.sv
// Instruction fetch front end: issues one held-until-complete request at a time,
// presents {valid, pc, instr} to decode through an output register plus one pending slot.
module fetch_ctrl #(
  parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        f_valid,
  output logic [63:0] f_pc,
  output logic [31:0] f_raw_instr,
  input  logic        stall,
  input  logic        jump,
  input  logic [63:0] pcsrc
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        ireq_valid_q, ireq_valid_d;
  logic [63:0] ireq_addr_q, ireq_addr_d;
  logic        f_valid_q, f_valid_d;
  logic [63:0] f_pc_q, f_pc_d;
  logic [31:0] f_raw_q, f_raw_d;
  logic        pend_valid_q, pend_valid_d;
  logic [63:0] pend_pc_q, pend_pc_d;
  logic [31:0] pend_raw_q, pend_raw_d;
  logic        drop_q, drop_d;
  logic [63:0] redir_pc_q, redir_pc_d;

  logic        fire_s, accept_s, redirect_s, slot_free_s;
  logic [63:0] target_s;

  always_comb begin
    fire_s       = ireq_valid_q & iresp_data_ok;
    accept_s     = f_valid_q & ~stall;
    redirect_s   = accept_s & jump;
    slot_free_s  = ~f_valid_q | accept_s;
    target_s     = {pcsrc[63:2], 2'b00};

    ireq_addr_d  = ireq_addr_q;
    f_valid_d    = f_valid_q;
    f_pc_d       = f_pc_q;
    f_raw_d      = f_raw_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    pend_raw_d   = pend_raw_q;
    drop_d       = drop_q;
    redir_pc_d   = redir_pc_q;

    if (redirect_s) begin
      f_valid_d    = 1'b0;
      pend_valid_d = 1'b0;
      if (fire_s) begin
        ireq_addr_d = target_s;
        drop_d      = 1'b0;
      end else if (ireq_valid_q) begin
        // Wrong-path request still in flight: keep the bus stable, squash its response later.
        drop_d     = 1'b1;
        redir_pc_d = target_s;
      end else begin
        ireq_addr_d = target_s;
        drop_d      = 1'b0;
      end
    end else begin
      if (accept_s) begin
        if (pend_valid_q) begin
          f_valid_d    = 1'b1;
          f_pc_d       = pend_pc_q;
          f_raw_d      = pend_raw_q;
          pend_valid_d = 1'b0;
        end else begin
          f_valid_d = 1'b0;
        end
      end else begin
        f_valid_d = f_valid_q;
      end

      if (fire_s && drop_q) begin
        drop_d      = 1'b0;
        ireq_addr_d = redir_pc_q;
      end else if (fire_s) begin
        ireq_addr_d = ireq_addr_q + 64'd4;
        if (slot_free_s && !pend_valid_q) begin
          f_valid_d = 1'b1;
          f_pc_d    = ireq_addr_q;
          f_raw_d   = iresp_data;
        end else begin
          pend_valid_d = 1'b1;
          pend_pc_d    = ireq_addr_q;
          pend_raw_d   = iresp_data;
        end
      end else begin
        drop_d = drop_q;
      end
    end

    // Fetching pauses only while the pending slot is occupied.
    ireq_valid_d = ~pend_valid_d;
  end

  // State registers; every output is driven straight from one of these.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ireq_valid_q <= 1'b0;
      ireq_addr_q  <= PC_RESET;
      f_valid_q    <= 1'b0;
      f_pc_q       <= 64'd0;
      f_raw_q      <= NOP;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= 64'd0;
      pend_raw_q   <= NOP;
      drop_q       <= 1'b0;
      redir_pc_q   <= 64'd0;
    end else begin
      ireq_valid_q <= ireq_valid_d;
      ireq_addr_q  <= ireq_addr_d;
      f_valid_q    <= f_valid_d;
      f_pc_q       <= f_pc_d;
      f_raw_q      <= f_raw_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      pend_raw_q   <= pend_raw_d;
      drop_q       <= drop_d;
      redir_pc_q   <= redir_pc_d;
    end
  end

  assign ireq_valid  = ireq_valid_q;
  assign ireq_addr   = ireq_addr_q;
  assign f_valid     = f_valid_q;
  assign f_pc        = f_pc_q;
  assign f_raw_instr = f_raw_q;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction fetch front end. Produces the fetch-stage record {valid, pc, raw_instr} that the decode stage consumes.
- Consumes decode's stall/jump/pcsrc back-channel.
- Drives the instruction bus with a held-until-complete request.
- Holds a 2-entry instruction queue (output reg + pending reg). Discards wrong-path responses after a redirect.

Parameters:
- PC_RESET, 64'h0000_0000_8000_0000, first fetch address after reset.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- ireq_valid  output  1  instruction request valid
- ireq_addr  output  64  request address; stable while ireq_valid until completion
- iresp_data_ok  input  1  request completes this cycle; iresp_data valid
- iresp_data  input  32  fetched instruction
- f_valid  output  1  output record valid
- f_pc  output  64  pc of presented instruction
- f_raw_instr  output  32  presented instruction
- stall  input  1  decode cannot accept this cycle
- jump  input  1  decode redirect; meaningful only when accepted
- pcsrc  input  64  redirect target

Behaviour:
- Reset (async, active-low), all outputs registered:
  - ireq_valid=0, ireq_addr=PC_RESET, f_valid=0, f_pc=0, f_raw_instr=32'h0000_0013 (NOP).
  - Internal: pend_valid=0, drop=0, redir_pc=0.
  - First cycle after deassert: ireq_valid=1, addr=PC_RESET.
- Reset asserted mid-request: state cleared immediately; any later data_ok is ignored until the new request is issued.
- accept = f_valid & ~stall. redirect = accept & jump. target = {pcsrc[63:2],2'b00}. jump is ignored when accept=0.
- Bus rule:
  - ireq_addr never changes while ireq_valid=1 and data_ok=0.
  - data_ok with ireq_valid=0 is ignored.
  - At most one request outstanding.
- data_ok, no redirect, drop=0:
  - Output slot free or freeing (f_valid=0 or accept): load {ireq_addr, data} into output reg. Next cycle ireq_addr+=4, ireq_valid=1.
  - Else: load into pend reg, pend_valid=1. ireq_valid=0 until pend drains.
- accept, no redirect:
  - pend_valid: pend moves to output reg, pend_valid=0. Request resumes next cycle at pend pc+4 (already in ireq_addr).
  - Else: f_valid=0 unless a data_ok load happens the same cycle.
- redirect (same cycle):
  - f_valid<=0, pend_valid<=0.
  - If ireq_valid & ~data_ok: drop<=1, redir_pc<=target.
  - If data_ok same cycle: response discarded; ireq_addr<=target, ireq_valid<=1.
  - If ireq_valid=0: ireq_addr<=target, ireq_valid<=1.
- data_ok with drop=1: response discarded, drop<=0. Next cycle ireq_addr<=redir_pc, ireq_valid=1.
- Redirect while drop=1: redir_pc overwritten with the newest target.
- Stall held indefinitely: output and pend stable; no requests; no loss.
- Address arithmetic is 64-bit modulo 2^64: pc 64'hFFFF_FFFF_FFFF_FFFC+4 wraps to 0.
- Latency: data_ok at cycle N → f_valid at N+1 (slot free). Redirect at N → request at target at N+1 (no outstanding request).

Test Plan:
- Reset release, data_ok every cycle with data=addr[31:0], stall=0 → ireq_addr 8000_0000, 8000_0004, 8000_0008…; f_pc trails by one cycle; f_raw_instr==f_pc[31:0].
- stall=1 for 5 cycles while output holds pc 8000_0004 and data_ok returns 8000_0008 → pend holds 8000_0008; ireq_valid=0 for the stall; after release f_pc shows 8000_0004, 8000_0008, then request 8000_000C.
- Redirect while request at 8000_0008 is outstanding (jump=1, pcsrc=8000_0100, data_ok arrives 3 cycles later) → ireq_addr held at 8000_0008 until data_ok; response dropped (f_valid stays 0); next request 8000_0100; next f_pc=8000_0100.
- Redirect in the same cycle as data_ok, pcsrc=8000_0203 → response dropped; next ireq_addr=8000_0200.
- Redirect with pend_valid=1 → both queued instructions squashed; f_valid=0 next cycle; first f_pc after redirect equals target.
- Assert reset while ireq_valid=1, then release with a stale data_ok on the first cycle → ireq_valid=1 at 8000_0000 on the first post-reset cycle; the stale data_ok must not set f_valid.
